// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file access arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arbState_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } reqBundle_t;

endpackage

// File: rtl/regfile_arb_pick.sv
// Two-way winner select; REGFILE_ARB_RR_EN selects round-robin ties, otherwise port 0 wins ties.
module regfile_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic lastWinner,
    output logic grant
);

    // grant: 0 = port 0, 1 = port 1; only meaningful when req0 | req1
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
`ifdef REGFILE_ARB_RR_EN
            grant = ~lastWinner;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = req1;
        end
    end

`ifndef REGFILE_ARB_RR_EN
    logic unusedLastWinner;
    assign unusedLastWinner = lastWinner;
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises two requesters onto the register file's write port and read mux.
// Define REGFILE_ARB_RR_EN for round-robin ties; default is fixed priority to port 0.
module regfile_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_dout
);
    import regfile_pkg::*;

    arbState_t  state;
    reqBundle_t chosen;
    logic       pick;
    logic       winner;
    logic       lastWinner;
    logic       anyReq;

    assign anyReq = req0 | req1;

    regfile_arb_pick uPick (
        .req0       (req0),
        .req1       (req1),
        .lastWinner (lastWinner),
        .grant      (pick)
    );

    always_comb begin
        chosen = pick ? '{we: we1, addr: addr1, wdata: wdata1}
                      : '{we: we0, addr: addr0, wdata: wdata0};
    end

`ifndef REGFILE_ARB_RR_EN
    assign lastWinner = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            winner   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            busy     <= 1'b0;
            rf_we    <= 1'b0;
            rf_sel   <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
`ifdef REGFILE_ARB_RR_EN
            lastWinner <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (anyReq) begin
                        winner   <= pick;
                        rf_sel   <= chosen.addr;
                        rf_waddr <= chosen.addr;
                        rf_wdata <= chosen.wdata;
                        rf_we    <= chosen.we;
                        busy     <= 1'b1;
                        state    <= StAccess;
`ifdef REGFILE_ARB_RR_EN
                        lastWinner <= pick;
`endif
                    end
                end
                StAccess: begin
                    // rf_we still reflects the latched direction on this edge
                    if (!rf_we) begin
                        if (winner) rdata1 <= rf_dout;
                        else        rdata0 <= rf_dout;
                    end
                    rf_we <= 1'b0;
                    ack0  <= ~winner;
                    ack1  <= winner;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    rf_we <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port access arbiter for the 8 x 8-bit register file. Shares the register file's single write port and the single 8:1 read multiplexer between two requesters, such as a control path and a DMA/debug path. The block serialises one complete access at a time, drives the file's select, write-enable, address and data lines, and returns read data with an acknowledge.

## Interface
- Parameters
- DATA_W, 8, register width
- ADDR_W, 3, register index width (8 registers)
- Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, held high until matching ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  register index; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read result, valid while ack high, held until next ack to that port
- busy  out  1  high in ACCESS and DONE states
- rf_sel  out  ADDR_W  read-mux select to register file
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write index
- rf_wdata  out  DATA_W  write data
- rf_dout  in  DATA_W  register-file read-mux output (combinational from rf_sel)

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when req0 | req1. The winner, its we, addr and wdata are latched at that edge.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
- In ACCESS: rf_sel = rf_waddr = latched addr. rf_we = latched we. rf_wdata = latched wdata. The file writes on the edge ending ACCESS. For a read, rf_dout is captured into the winner's rdata register on that same edge.
- Outside ACCESS: rf_we = 0 and rf_sel holds its last value. rf_waddr and rf_wdata hold their last values.
- In DONE: ack of the winner = 1, all other acks = 0. For a write, rdata of the winner is unchanged.
- Arbitration happens only in IDLE.
  - With one request pending, that requester wins.
  - With both pending, the policy is set by Configuration.
- A requester sampled high again in the IDLE after its ack counts as a new request. Requesters drop req in the ack cycle to avoid a repeat.
- Access ordering between ports is strictly grant order. A read granted after a write to the same index returns the new value.
- The last-winner pointer updates at the IDLE→ACCESS edge.

## Timing
- req rises before edge k (FSM in IDLE) → ACCESS in cycle k+1 → ack in cycle k+2. Request-to-ack latency is 2 cycles.
- Maximum throughput is one access per 3 cycles.
- Reset values: state = IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, busy = 0, rf_we = 0, rf_sel = rf_waddr = 0, rf_wdata = 0, last-winner = 1 (port 0 wins first).
- Reset asserted mid-access: outputs go to reset values immediately (asynchronous). rf_we drops with no completion, no ack is issued, and the aborted request must be re-issued.
- req deasserted during ACCESS or DONE (protocol violation): the access still completes and ack still pulses.

## Configuration
- REGFILE_ARB_RR_EN defined: round-robin. With both requests pending, the port that was not the last winner is granted.
- REGFILE_ARB_RR_EN undefined: fixed priority. Port 0 always wins a tie, the last-winner register is not implemented, and port 1 can starve.

## Structure
- Package regfile_pkg holds:
  - DATA_W = 8 and ADDR_W = 3 constants
  - the FSM state typedef (IDLE, ACCESS, DONE)
  - a request-bundle struct {we, addr, wdata}
- Sub-module regfile_arb_pick: combinational 2-way winner select from req0, req1 and last-winner. It contains the REGFILE_ARB_RR_EN conditional.
- The FSM, latches and rdata registers stay in the top level.

## Test plan
- Reset then idle → all outputs 0, busy = 0, no ack for 10 cycles.
- Port 0 writes reg 5 = 8'hA5, then port 0 reads reg 5 → rf_we high for exactly 1 cycle, ack0 2 cycles after each req, rdata0 = 8'hA5.
- req0 and req1 rise together, both reads (reg 1 preloaded 8'h11, reg 2 preloaded 8'h22), each held until ack:
  - RR_EN: ack0 then ack1 three cycles apart.
  - Without RR_EN and req0 continuously re-asserted: port 1 never acked.
- Port 1 write reg 7 = 8'h3C and port 0 read reg 7 pending together, port 1 last winner = 0 → write first, rdata0 = 8'h3C.
- Reset pulsed in ACCESS of a write → rf_we falls asynchronously, no ack, FSM returns to IDLE, and a re-issued request completes normally.
- Sweep all 8 indices from both ports, write then read back → every rdata matches and rf_sel equals the addr used during ACCESS.
